fp_addsub_seq: RTL and testbench



---
 rtl/fp_pkg.sv | 33 +++
 rtl/fp_special_detect.sv | 43 ++++
 rtl/fp_addsub_seq.sv | 159 +++++++++++++++
 tb/tb_fp_addsub_seq.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the sequential FP add/sub unit: FSM states,
// IEEE-754 single-precision constants and field extractors.
package fp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_SPECIAL,
    S_DONE
  } state_t;

  localparam int          BIAS    = 127;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  function automatic logic fp_sign(input logic [31:0] w);
    return w[31];
  endfunction

  function automatic logic [7:0] fp_expo(input logic [31:0] w);
    return w[30:23];
  endfunction

  function automatic logic [22:0] fp_ment(input logic [31:0] w);
    return w[22:0];
  endfunction

endpackage

// File: rtl/fp_special_detect.sv
// Classifies both operands (zero/inf/NaN) and forms the result of the
// one-cycle special-case path. Denormals are treated as zero.
module fp_special_detect #(
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  a_sign,
  input  logic [EXPO_WIDTH-1:0] a_exp,
  input  logic [MENT_WIDTH-1:0] a_frac,
  input  logic                  b_sign,
  input  logic [EXPO_WIDTH-1:0] b_exp,
  input  logic [MENT_WIDTH-1:0] b_frac,
  output logic [DATA_WIDTH-1:0] result
);
  localparam logic [EXPO_WIDTH-1:0] EXP_ONES = '1;

  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
  assign b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
  assign a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
  assign b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);

  always_comb begin
    result = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign)))
      result = {1'b0, EXP_ONES, 1'b1, {(MENT_WIDTH-1){1'b0}}};
    else if (a_inf)
      result = {a_sign, EXP_ONES, {MENT_WIDTH{1'b0}}};
    else if (b_inf)
      result = {b_sign, EXP_ONES, {MENT_WIDTH{1'b0}}};
    else if (a_zero && b_zero)
      result = {a_sign & b_sign, {(DATA_WIDTH-1){1'b0}}};
    else if (a_zero)
      result = {b_sign, b_exp, b_frac};
    else
      result = {a_sign, a_exp, a_frac};
  end

endmodule

// File: rtl/fp_addsub_seq.sv
// Handshaked multi-cycle FP add/sub: align one bit per cycle, add, normalize
// one bit per cycle, round. FP_ROUND_NEAREST_EN selects RNE, else truncate.
module fp_addsub_seq
  import fp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [DATA_WIDTH-1:0] floating1_in,
  input  logic [DATA_WIDTH-1:0] floating2_in,
  input  logic                  opcode_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] floating_result_out
);
  localparam int DW = DATA_WIDTH;
  localparam int MW = MENT_WIDTH;
  localparam int EW = EXPO_WIDTH;
  localparam int XW = MENT_WIDTH + 4;  // hidden + fraction + G/R/S
  localparam logic [EW-1:0] EXP_ONES  = '1;
  localparam logic [EW-1:0] EXP_ONE   = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0] SHIFT_MAX = EW'(MW + 3);

  state_t        state;
  logic          a_sign, b_sign, r_sign;
  logic [EW-1:0] a_exp, b_exp, r_exp, diff;
  logic [XW-1:0] a_man, b_man, r_man;

  // Order operands by magnitude at capture so A is always the larger side.
  logic [DW-1:0] op_b, op_hi, op_lo;
  logic [EW-1:0] hi_exp, lo_exp, e1, e2;
  logic          in_swap, in_special;

  assign op_b       = {floating2_in[DW-1] ^ opcode_in, floating2_in[DW-2:0]};
  assign in_swap    = floating2_in[DW-2:0] > floating1_in[DW-2:0];
  assign op_hi      = in_swap ? op_b : floating1_in;
  assign op_lo      = in_swap ? floating1_in : op_b;
  assign hi_exp     = op_hi[DW-2:MW];
  assign lo_exp     = op_lo[DW-2:MW];
  assign e1         = floating1_in[DW-2:MW];
  assign e2         = floating2_in[DW-2:MW];
  assign in_special = (e1 == EXP_ONES) || (e1 == '0) || (e2 == EXP_ONES) || (e2 == '0);

  logic [XW:0] sum;
  assign sum = (a_sign == b_sign) ? ({1'b0, a_man} + {1'b0, b_man})
                                  : ({1'b0, a_man} - {1'b0, b_man});

  logic          rnd_inc;
  logic [MW+1:0] rnd_man;
  logic [EW:0]   rnd_exp;
  logic [DW-1:0] rnd_word, spec_word;

`ifdef FP_ROUND_NEAREST_EN
  assign rnd_inc = r_man[2] & (r_man[1] | r_man[0] | r_man[3]);
`else
  assign rnd_inc = 1'b0;
`endif

  // Rounding carry into bit MW+1 renormalizes within the same cycle.
  assign rnd_man  = {1'b0, r_man[XW-1:3]} + {{(MW+1){1'b0}}, rnd_inc};
  assign rnd_exp  = {1'b0, r_exp} + {{EW{1'b0}}, rnd_man[MW+1]};
  assign rnd_word = (rnd_exp >= {1'b0, EXP_ONES}) ? {r_sign, EXP_ONES, {MW{1'b0}}}
                  : {r_sign, rnd_exp[EW-1:0], rnd_man[MW+1] ? rnd_man[MW:1] : rnd_man[MW-1:0]};

  fp_special_detect #(
    .MENT_WIDTH(MW), .EXPO_WIDTH(EW), .DATA_WIDTH(DW)
  ) u_special (
    .a_sign(a_sign), .a_exp(a_exp), .a_frac(a_man[XW-2:3]),
    .b_sign(b_sign), .b_exp(b_exp), .b_frac(b_man[XW-2:3]),
    .result(spec_word)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state               <= S_IDLE;
      ready_out           <= 1'b1;
      valid_out           <= 1'b0;
      floating_result_out <= '0;
      a_sign <= 1'b0; b_sign <= 1'b0; r_sign <= 1'b0;
      a_exp  <= '0;   b_exp  <= '0;   r_exp  <= '0;   diff <= '0;
      a_man  <= '0;   b_man  <= '0;   r_man  <= '0;
    end else begin
      case (state)
        S_IDLE: if (valid_in && ready_out) begin
          ready_out <= 1'b0;
          a_sign    <= op_hi[DW-1];
          a_exp     <= hi_exp;
          a_man     <= {1'b1, op_hi[MW-1:0], 3'b000};
          b_sign    <= op_lo[DW-1];
          b_exp     <= lo_exp;
          b_man     <= {1'b1, op_lo[MW-1:0], 3'b000};
          diff      <= hi_exp - lo_exp;
          // Equal exponents need no shifts and skip straight to ADD.
          state     <= in_special ? S_SPECIAL : (hi_exp == lo_exp) ? S_ADD : S_ALIGN;
        end
        S_ALIGN: begin
          if (diff > SHIFT_MAX) begin
            b_man <= {{(XW-1){1'b0}}, |b_man};
            diff  <= '0;
            state <= S_ADD;
          end else begin
            b_man <= {1'b0, b_man[XW-1:2], b_man[1] | b_man[0]};
            diff  <= diff - 1'b1;
            if (diff == EXP_ONE) state <= S_ADD;
          end
        end
        S_ADD: begin
          r_sign <= a_sign;
          if (sum == '0) begin
            floating_result_out <= '0;
            valid_out           <= 1'b1;
            state               <= S_DONE;
          end else if (sum[XW]) begin
            r_man <= {sum[XW:2], sum[1] | sum[0]};
            r_exp <= a_exp + 1'b1;
            state <= S_ROUND;
          end else begin
            r_man <= sum[XW-1:0];
            r_exp <= a_exp;
            state <= sum[XW-1] ? S_ROUND : S_NORM;
          end
        end
        S_NORM: begin
          if (r_exp == EXP_ONE) begin
            floating_result_out <= {r_sign, {(DW-1){1'b0}}};
            valid_out           <= 1'b1;
            state               <= S_DONE;
          end else begin
            r_man <= r_man << 1;
            r_exp <= r_exp - 1'b1;
            if (r_man[XW-2]) state <= S_ROUND;
          end
        end
        S_ROUND: begin
          floating_result_out <= rnd_word;
          valid_out           <= 1'b1;
          state               <= S_DONE;
        end
        S_SPECIAL: begin
          floating_result_out <= spec_word;
          valid_out           <= 1'b1;
          state               <= S_DONE;
        end
        S_DONE: if (ready_in) begin
          valid_out <= 1'b0;
          ready_out <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed vector table plus back-pressure and mid-operation reset sequences
// for fp_addsub_seq; latency counts clock edges from the accepting edge.
module tb_fp_addsub_seq;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0, ready_in = 1'b0, opcode = 1'b0;
  logic        ready_out, valid_out;
  logic [31:0] f1 = '0, f2 = '0, res;
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  fp_addsub_seq dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .valid_in(valid_in), .ready_out(ready_out),
    .floating1_in(f1), .floating2_in(f2), .opcode_in(opcode),
    .valid_out(valid_out), .ready_in(ready_in),
    .floating_result_out(res)
  );

`ifdef FP_ROUND_NEAREST_EN
  localparam logic [31:0] EXP_HALF_UP = 32'h3F80_0001;
  localparam logic [31:0] EXP_CLAMP_SUB = 32'h4D80_0000;
`else
  localparam logic [31:0] EXP_HALF_UP = 32'h3F80_0000;
  localparam logic [31:0] EXP_CLAMP_SUB = 32'h4D7F_FFFF;
`endif

  typedef struct {
    string       name;
    logic [31:0] a, b;
    logic        op;
    logic [31:0] res;
    int          lat;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one op, wait (bounded) for valid_out, check latency/result, pop it.
  task automatic run_op(input vec_t v);
    int n;
    check({v.name, " ready"}, {31'b0, ready_out}, 32'd1);
    f1 = v.a; f2 = v.b; opcode = v.op; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    n = 1;
    while (!valid_out && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_int({v.name, " latency"}, n, v.lat);
    check({v.name, " result"}, res, v.res);
    ready_in = 1'b1;
    @(posedge clk); #1;
    ready_in = 1'b0;
    check({v.name, " pop"}, {30'b0, valid_out, ready_out}, 32'd1);
  endtask

  initial begin
    tbl.push_back('{"add",        32'h4387_6000, 32'h4018_0000, 1'b0, 32'h4388_9000, 10});
    tbl.push_back('{"sub",        32'h4387_6000, 32'h4018_0000, 1'b1, 32'h4386_3000, 10});
    tbl.push_back('{"sub_swap",   32'h4018_0000, 32'h4387_6000, 1'b1, 32'hC386_3000, 10});
    tbl.push_back('{"sub_self",   32'h4387_6000, 32'h4387_6000, 1'b1, 32'h0000_0000, 2});
    tbl.push_back('{"inf_m_inf",  POS_INF,       NEG_INF,       1'b0, QNAN,          2});
    tbl.push_back('{"overflow",   32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, POS_INF,       3});
    tbl.push_back('{"tie_even",   32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 27});
    tbl.push_back('{"lsb_add",    32'h3F80_0000, 32'h3400_0000, 1'b0, 32'h3F80_0001, 26});
    tbl.push_back('{"above_half", 32'h3F80_0000, 32'h33C0_0000, 1'b0, EXP_HALF_UP,   27});
    tbl.push_back('{"diff26",     32'h3F80_0000, 32'h3280_0000, 1'b0, 32'h3F80_0000, 29});
    tbl.push_back('{"clamp_add",  32'h4D80_0000, 32'h3F80_0000, 1'b0, 32'h4D80_0000, 4});
    tbl.push_back('{"clamp_sub",  32'h4D80_0000, 32'h3F80_0000, 1'b1, EXP_CLAMP_SUB, 5});
    tbl.push_back('{"norm4",      32'h4018_0000, 32'h4010_0000, 1'b1, 32'h3E00_0000, 7});
    tbl.push_back('{"flush_neg",  32'h8080_0001, 32'h8080_0000, 1'b1, 32'h8000_0000, 3});
    tbl.push_back('{"carry",      32'h4018_0000, 32'h4018_0000, 1'b0, 32'h4098_0000, 3});
    tbl.push_back('{"nan",        32'h7FC1_2345, 32'h3F80_0000, 1'b0, QNAN,          2});
    tbl.push_back('{"inf_m_one",  POS_INF,       32'h3F80_0000, 1'b1, POS_INF,       2});
    tbl.push_back('{"ninf_ninf",  NEG_INF,       NEG_INF,       1'b0, NEG_INF,       2});
    tbl.push_back('{"nz_nz",      32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 2});
    tbl.push_back('{"nz_m_z",     32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, 2});
    tbl.push_back('{"z_m_nz",     32'h0000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 2});
    tbl.push_back('{"z_pass",     32'h0000_0000, 32'hC040_0000, 1'b0, 32'hC040_0000, 2});
    tbl.push_back('{"denorm",     32'h0001_2345, 32'h3F80_0000, 1'b1, 32'hBF80_0000, 2});

    #12;
    check("reset", {res[31:0]}, 32'h0);
    check("reset hs", {30'b0, valid_out, ready_out}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) run_op(tbl[i]);

    // Back-pressure: result held for 10 cycles while a new request is offered.
    begin
      int n;
      f1 = 32'h4387_6000; f2 = 32'h4018_0000; opcode = 1'b0; valid_in = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0;
      n = 1;
      while (!valid_out && n < 200) begin @(posedge clk); #1; n++; end
      check_int("bp latency", n, 10);
      f1 = 32'h3F80_0000; f2 = 32'h3F80_0000; valid_in = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        check("bp hold hs", {30'b0, valid_out, ready_out}, 32'd2);
        check("bp hold res", res, 32'h4388_9000);
      end
      ready_in = 1'b1;
      @(posedge clk); #1;
      ready_in = 1'b0; valid_in = 1'b0;
      check("bp pop no accept", {30'b0, valid_out, ready_out}, 32'd1);
      @(posedge clk); #1;
      check("bp idle", {30'b0, valid_out, ready_out}, 32'd1);
    end

    // Reset asserted while the unit is normalizing.
    f1 = 32'h4018_0000; f2 = 32'h4010_0000; opcode = 1'b1; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid rst hs", {30'b0, valid_out, ready_out}, 32'd1);
    check("mid rst res", res, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op('{"post_rst", 32'h4018_0000, 32'h4018_0000, 1'b0, 32'h4098_0000, 3});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
